// File: rtl/filter_output_decimator_pkg.sv
// Shared widths and defaults for the filter output path; the FIR core uses the same values.
package filter_output_decimator_pkg;
  localparam int SAMPLE_W           = 8;
  localparam int DEC_LOG2_DEFAULT   = 2;
  localparam int DROP_CNT_W         = 8;
  localparam int FIFO_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/filter_result_fifo.sv
// Synchronous result FIFO. A push while full is taken only if a pop happens on the same edge.
module filter_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/filter_output_decimator.sv
// Block-averages every 2**LOG2_DEC filter samples and queues the averages for the output logic.
// Output handshake: out_data is transferred on any edge where out_valid && out_ready; out_valid never depends on out_ready.
module filter_output_decimator
  import filter_output_decimator_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int LOG2_DEC   = DEC_LOG2_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  clear,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int ACC_W    = DATA_W + LOG2_DEC;
  localparam int WIN_LAST = (1 << LOG2_DEC) - 1;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [LOG2_DEC-1:0] win_cnt;
  logic [DATA_W-1:0]   result;
  logic                accept;
  logic                close;
  logic                pop;
  logic                full;
  logic                empty;
  logic                drop;

  assign accept   = in_valid && !clear;
  assign close    = accept && (win_cnt == LOG2_DEC'(WIN_LAST));
  assign acc_next = acc + ACC_W'(in_data);
  // Truncating divide; the extra LOG2_DEC bits keep a full window of max samples exact.
  assign result   = DATA_W'(acc_next >> LOG2_DEC);
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;
  assign drop     = close && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (clear || close) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (accept) begin
      acc     <= acc_next;
      win_cnt <= win_cnt + LOG2_DEC'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

  filter_result_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (close),
    .push_data (result),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (out_data)
  );
endmodule

// File: tb/tb_filter_output_decimator.sv
// Randomized plus directed bench for filter_output_decimator against a window/queue reference model.
module tb_filter_output_decimator;
  localparam int W     = 8;
  localparam int WIN   = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         clear;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         overflow;
  logic [7:0]   drop_cnt;

  filter_output_decimator dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending window samples, expected FIFO contents, sticky flags.
  logic [W-1:0] exp_q[$];
  int           win_q[$];
  logic         m_ovf;
  int           m_drop;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic clr,
                            input logic rdy, input logic rst);
    int sum;
    if (rst) begin
      exp_q.delete();
      win_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
      if (clr) win_q.delete();
      else if (v) begin
        win_q.push_back(int'(d));
        if (win_q.size() == WIN) begin
          sum = 0;
          foreach (win_q[i]) sum += win_q[i];
          win_q.delete();
          if (exp_q.size() < DEPTH) exp_q.push_back(W'(sum / WIN));
          else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic clr,
                      input logic rdy, input logic rst);
    in_valid  = v;
    in_data   = d;
    clear     = clr;
    out_ready = rdy;
    reset     = rst;
    @(posedge clk);
    model_edge(v, d, clr, rdy, rst);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("out_data", 32'(out_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic sample(input logic [W-1:0] d, input logic rdy);
    step(1'b1, d, 1'b0, rdy, 1'b0);
  endtask

  task automatic window(input logic [W-1:0] d, input logic rdy);
    for (int i = 0; i < WIN; i++) sample(d, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    m_ovf = 1'b0;
    m_drop = 0;
    // reset state
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    // 10,20,30,40 -> 25, valid right after the 4th sample
    sample(8'd10, 1'b0); sample(8'd20, 1'b0); sample(8'd30, 1'b0);
    check("t1_not_yet", 32'(out_valid), 32'd0);
    sample(8'd40, 1'b0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_avg", 32'(out_data), 32'd25);
    drain();

    window(8'd255, 1'b0);
    check("t2_max", 32'(out_data), 32'd255);
    drain();
    sample(8'd1, 1'b0); sample(8'd1, 1'b0); sample(8'd1, 1'b0); sample(8'd2, 1'b0);
    check("t2_trunc", 32'(out_data), 32'd1);
    drain();

    // clear discards partial window; a sample presented with clear is ignored
    sample(8'd8, 1'b0); sample(8'd8, 1'b0);
    step(1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
    window(8'd4, 1'b0);
    check("t3_avg", 32'(out_data), 32'd4);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check("t3_single", 32'(out_valid), 32'd0);

    // overflow: 5 windows with no consumer
    for (int k = 1; k <= 5; k++) window(W'(k), 1'b0);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_drop", 32'(drop_cnt), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      check("t4_order", 32'(out_data), 32'(k));
      step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    end
    check("t4_empty", 32'(out_valid), 32'd0);

    // full FIFO with pop on the window-close edge: no drop
    for (int k = 1; k <= 4; k++) window(W'(k), 1'b0);
    sample(8'd9, 1'b0); sample(8'd9, 1'b0); sample(8'd9, 1'b0); sample(8'd9, 1'b1);
    check("t5_drop", 32'(drop_cnt), 32'd1);
    check("t5_head", 32'(out_data), 32'd2);
    for (int k = 0; k < 3; k++) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    check("t5_new", 32'(out_data), 32'd9);
    drain();

    // reset mid-window with two queued results
    window(8'd6, 1'b0); window(8'd7, 1'b0);
    sample(8'd50, 1'b0);
    step(1'b1, 8'd50, 1'b0, 1'b0, 1'b1);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data", 32'(out_data), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    window(8'd2, 1'b0);
    check("t6_avg", 32'(out_data), 32'd2);
    drain();

    // random traffic
    for (int i = 0; i < 2000; i++)
      step(logic'($urandom_range(0, 3) != 0), W'($urandom_range(0, 255)),
           logic'($urandom_range(0, 31) == 0), logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 499) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
